// File: rtl/stream_len_fifo_if.sv
// Handshake bundle for stream_len_fifo: shared config bus, producer stream,
// consumer stream and transfer status.
interface stream_len_fifo_if #(
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [CONFIG_AWIDTH-1:0] cfg_addr;
    logic [CONFIG_DWIDTH-1:0] cfg_data;
    logic                     cfg_valid;

    logic [DATA_WIDTH-1:0]    up_data;
    logic                     up_valid;
    logic                     up_ready;

    logic [DATA_WIDTH-1:0]    down_data;
    logic                     down_valid;
    logic                     down_ready;

    logic                     busy;
    logic                     done;

    modport master (
        output cfg_addr, cfg_data, cfg_valid,
        output up_data, up_valid,
        input  up_ready,
        input  down_data, down_valid,
        output down_ready,
        input  busy, done
    );

    modport slave (
        input  cfg_addr, cfg_data, cfg_valid,
        input  up_data, up_valid,
        output up_ready,
        output down_data, down_valid,
        input  down_ready,
        output busy, done
    );
endinterface

// File: rtl/stream_len_fifo.sv
// Length-bounded FWFT FIFO between a producer stream and axis_write: armed by an
// ID word then a length word on the config bus, it passes exactly len words.
module stream_len_fifo #(
    parameter int BUF_AWIDTH    = 4,
    parameter int CONFIG_ID     = 1,
    parameter int CONFIG_ADDR   = 23,
    parameter int CONFIG_DATA   = 24,
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst,
    stream_len_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << BUF_AWIDTH;
    localparam logic [CONFIG_AWIDTH-1:0] L_ID_ADDR  = CONFIG_AWIDTH'(CONFIG_ADDR);
    localparam logic [CONFIG_AWIDTH-1:0] L_LEN_ADDR = CONFIG_AWIDTH'(CONFIG_DATA);
    localparam logic [CONFIG_DWIDTH-1:0] L_UNIT_ID  = CONFIG_DWIDTH'(CONFIG_ID);
    localparam logic [BUF_AWIDTH:0]      L_FULL     = (BUF_AWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CONFIG, ACTIVE, DRAIN} state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [BUF_AWIDTH-1:0]    r_wr_ptr;
    logic [BUF_AWIDTH-1:0]    r_rd_ptr;
    logic [BUF_AWIDTH:0]      r_count;
    logic [CONFIG_DWIDTH-1:0] r_len;
    logic [CONFIG_DWIDTH-1:0] r_in_cnt;
    logic [CONFIG_DWIDTH-1:0] r_out_cnt;
    logic                     r_done;

    logic w_full;
    logic w_empty;
    logic w_streaming;
    logic w_up_ready;
    logic w_down_valid;
    logic w_push;
    logic w_pop;
    logic w_in_last;
    logic w_out_last;
    logic w_id_hit;
    logic w_load_len;
    logic w_set_done;

    assign w_full       = (r_count == L_FULL);
    assign w_empty      = (r_count == '0);
    assign w_streaming  = (r_state == ACTIVE) || (r_state == DRAIN);
    // Full blocks the push even when a pop happens in the same cycle.
    assign w_up_ready   = (r_state == ACTIVE) && !w_full && (r_in_cnt < r_len);
    assign w_down_valid = w_streaming && !w_empty;
    assign w_push       = bus.up_valid && w_up_ready;
    assign w_pop        = w_down_valid && bus.down_ready;
    assign w_in_last    = ((r_in_cnt + CONFIG_DWIDTH'(1)) == r_len);
    assign w_out_last   = ((r_out_cnt + CONFIG_DWIDTH'(1)) == r_len);
    assign w_id_hit     = (bus.cfg_data == L_UNIT_ID);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load_len   = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cfg_valid && (bus.cfg_addr == L_ID_ADDR) && w_id_hit)
                    w_state_next = CONFIG;
            end
            CONFIG: begin
                if (bus.cfg_valid && (bus.cfg_addr == L_LEN_ADDR)) begin
                    w_load_len   = 1'b1;
                    w_state_next = (bus.cfg_data != '0) ? ACTIVE : IDLE;
                end else if (bus.cfg_valid && (bus.cfg_addr == L_ID_ADDR) && !w_id_hit) begin
                    w_state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (w_push && w_in_last)
                    w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_pop && w_out_last) begin
                    w_state_next = IDLE;
                    w_set_done   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_set_done;
            if (w_load_len) begin
                r_len     <= bus.cfg_data;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_push) r_in_cnt  <= r_in_cnt + CONFIG_DWIDTH'(1);
                if (w_pop)  r_out_cnt <= r_out_cnt + CONFIG_DWIDTH'(1);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + BUF_AWIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + BUF_AWIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (BUF_AWIDTH+1)'(1);
                2'b01:   r_count <= r_count - (BUF_AWIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and count
    // already marks it empty, and down_data is don't-care while down_valid=0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.up_data;
    end

    assign bus.up_ready   = w_up_ready;
    assign bus.down_valid = w_down_valid;
    assign bus.down_data  = r_mem[r_rd_ptr];
    assign bus.busy       = w_streaming;
    assign bus.done       = r_done;
endmodule

// File: doc/stream_len_fifo.md
STREAM_LEN_FIFO -- requirements
Module: stream_len_fifo

Interface
REQ-001 SHALL have parameter BUF_AWIDTH, default 4, FIFO address width (depth 2^BUF_AWIDTH = 16).
REQ-002 SHALL have parameter CONFIG_ID, default 1, unit ID matched on the config bus.
REQ-003 SHALL have parameter CONFIG_ADDR, default 23, cfg address carrying the ID select word.
REQ-004 SHALL have parameter CONFIG_DATA, default 24, cfg address carrying the length word.
REQ-005 SHALL have parameters CONFIG_AWIDTH (default 5), CONFIG_DWIDTH (default 32) and DATA_WIDTH (default 32), the cfg address, cfg data and stream widths.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have ports cfg_addr  input  CONFIG_AWIDTH, cfg_data  input  CONFIG_DWIDTH and cfg_valid  input  1, forming the shared config bus, with no backpressure.
REQ-009 SHALL have ports up_data  input  DATA_WIDTH, up_valid  input  1 and up_ready  output  1, forming the producer stream.
REQ-010 SHALL have ports down_data  output  DATA_WIDTH, down_valid  output  1 and down_ready  input  1, forming the stream into the axis_write data port.
REQ-011 SHALL have ports busy  output  1 (transfer active) and done  output  1 (one-cycle completion pulse).

Function
REQ-012 SHALL transfer a word on either stream only in a cycle where valid and ready are both high at the rising edge.
REQ-013 SHALL implement FSM states IDLE, CONFIG, ACTIVE and DRAIN.
REQ-014 SHALL go from IDLE to CONFIG on cfg_valid with cfg_addr==CONFIG_ADDR and cfg_data==CONFIG_ID, and SHALL ignore every other cfg word in IDLE.
REQ-015 In CONFIG, on cfg_valid with cfg_addr==CONFIG_DATA, SHALL load len=cfg_data and clear the in/out counters; it SHALL enter ACTIVE when len!=0 and return to IDLE when len==0, with no done pulse.
REQ-016 In CONFIG, on cfg_valid with cfg_addr==CONFIG_ADDR and a non-matching ID, SHALL return to IDLE; all other cfg words SHALL be ignored.
REQ-017 SHALL ignore all cfg traffic in ACTIVE and DRAIN, with no re-arm mid-transfer.
REQ-018 SHALL drive up_ready = (state==ACTIVE) && !full && (in_cnt<len); no upstream word SHALL be accepted beyond len.
REQ-019 SHALL enter DRAIN from ACTIVE on the edge where in_cnt reaches len.
REQ-020 SHALL drive down_valid = !empty in ACTIVE and DRAIN, and 0 in IDLE/CONFIG.
REQ-021 SHALL present the FIFO head, first-word-fall-through, on down_data.
REQ-022 SHALL give minimum latency of 1 cycle: a word accepted at edge N SHALL be valid on down_data after edge N.
REQ-023 SHALL determine full from count==2^BUF_AWIDTH; when full, push SHALL be blocked even in a cycle with a simultaneous pop.
REQ-024 SHALL push and pop in the same cycle when not full and not empty, leaving the count unchanged.
REQ-025 SHALL let read/write pointers wrap modulo 2^BUF_AWIDTH, with the count of BUF_AWIDTH+1 bits distinguishing full from empty.
REQ-026 SHALL use in_cnt, out_cnt and len of CONFIG_DWIDTH bits, unsigned.
REQ-027 SHALL pulse done for exactly one cycle and move to IDLE on the edge where out_cnt reaches len.
REQ-028 SHALL drive busy=1 in ACTIVE and DRAIN, and 0 otherwise.
REQ-029 SHALL hold down_data stable while down_valid=1 and down_ready=0.

Reset
REQ-030 On rst low, SHALL immediately (asynchronously) enter IDLE, clear pointers, count, in_cnt, out_cnt and len, and drive up_ready=0, down_valid=0, busy=0 and done=0.
REQ-031 SHALL discard FIFO contents on reset asserted mid-transfer, with no done pulse; down_data after reset SHALL be treated as don't-care while down_valid=0.
REQ-032 SHALL resume operation on the first rising edge after rst returns high, and SHALL need a fresh ID and length sequence to start.

Verification
REQ-033 Basic: ID 1 to addr 23, then len 5 to addr 24, up_valid held with data 1..5 and down_ready=1 -> down emits 1,2,3,4,5 in order, first word one cycle after its accept, done pulses once, busy falls after done.
REQ-034 Backpressure/full: len 20 with down_ready=0 -> up_ready drops after 16 accepts; with down_ready=1 the remaining 4 are accepted and all 20 words are emitted in order across the pointer wrap.
REQ-035 Length cap: len 3 with upstream offering 10 words -> exactly 3 accepted, up_ready=0 afterwards, done pulses once.
REQ-036 Config filtering: ID 2 to addr 23, then len 4 to addr 24 -> stays IDLE; len 0 after a valid ID -> IDLE with no done; cfg writes during ACTIVE do not change len.
REQ-037 Reset mid-transfer: len 8, assert rst after 4 accepts and 2 emits -> outputs go to reset values at once, and the next transfer of len 2 emits only its own 2 words.
REQ-038 Simultaneous push/pop: len 32 with both sides valid/ready every cycle -> count stays at 1 in steady state, one word per cycle, done when out_cnt=32.
